// File: rtl/vslc_spi_target_pkg.sv
// Shared types and constants for the VSLC SPI target.
`timescale 1ns/1ps
package vslc_spi_target_pkg;

  localparam int SPI_BYTE_W = 8;
  localparam int CMD_RW_BIT = 7;

  typedef enum logic [2:0] {
    ST_WAIT_IDLE = 3'd0,
    ST_IDLE      = 3'd1,
    ST_CMD       = 3'd2,
    ST_WR        = 3'd3,
    ST_RD        = 3'd4
  } spi_state_e;

  // MSB-first serial shift: new bit enters at the LSB.
  function automatic logic [SPI_BYTE_W-1:0] shift_in(input logic [SPI_BYTE_W-1:0] cur,
                                                      input logic                  bit_in);
    return {cur[SPI_BYTE_W-2:0], bit_in};
  endfunction

endpackage

// File: rtl/vslc_spi_target_if.sv
// Simple register bus between the SPI target (master) and the register window (slave).
`timescale 1ns/1ps
interface vslc_spi_target_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [DATA_W-1:0] reg_rdata;

  modport master (
    output reg_addr,
    output reg_wdata,
    output reg_we,
    output reg_re,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr,
    input  reg_wdata,
    input  reg_we,
    input  reg_re,
    output reg_rdata
  );
endinterface

// File: rtl/vslc_spi_target_sync.sv
// Multi-flop synchronizer for one SPI pin with rise/fall pulses taken after the chain.
// Everything resets to 0 so that a chip select held low across reset looks like a frame
// in progress and is not mistaken for a fresh falling edge.
`timescale 1ns/1ps
module vslc_spi_target_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Shift the pin through the synchronizer and keep one extra stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = q_o & ~hist_q;
  assign fall_o = ~q_o & hist_q;

endmodule

// File: rtl/vslc_spi_target.sv
// SPI mode-0 target giving an external host read/write access to the VSLC register window.
// All SPI pins are oversampled in the clk domain; spi_sck never clocks any logic.
//
// state        | meaning
// ST_WAIT_IDLE | after reset, ignore the bus until cs_n is seen high
// ST_IDLE      | deselected, waiting for a cs_n falling edge
// ST_CMD       | shifting in the command byte {rw, addr}
// ST_WR        | write frame: every full byte strobes reg_we, then addr advances
// ST_RD        | read frame: miso from tx shifter, every full byte prefetches the next addr
`timescale 1ns/1ps
module vslc_spi_target
  import vslc_spi_target_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             spi_sck_i,
  input  logic             spi_cs_n_i,
  input  logic             spi_mosi_i,
  output logic             spi_miso_o,
  output logic             spi_miso_oe_o,
  output logic             busy_o,
  vslc_spi_target_if.master bus
);

  logic sck_s, sck_rise, sck_fall;
  logic cs_n_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_state_e state_q, state_d;

  logic [SPI_BYTE_W-1:0] rx_q, rx_d;
  logic [SPI_BYTE_W-1:0] tx_q, tx_d;
  logic [SPI_BYTE_W-1:0] rx_byte;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [ADDR_W-1:0]     bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  re_q, re_d;
  logic                  load_q, load_d;
  logic                  byte_done;

  vslc_spi_target_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (spi_sck_i),
    .q_o    (sck_s),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  vslc_spi_target_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (spi_cs_n_i),
    .q_o    (cs_n_s),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  vslc_spi_target_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (spi_mosi_i),
    .q_o    (mosi_s),
    .rise_o (mosi_rise),
    .fall_o (mosi_fall)
  );

  // Only the sck edges and the mosi level are needed from these instances.
  assign unused_sync = &{1'b0, sck_s, mosi_rise, mosi_fall};

  assign rx_byte   = shift_in(rx_q, mosi_s);
  assign byte_done = sck_rise && (bit_cnt_q == 3'd7);

  // Next-state logic: bit/byte framing, address sequencing and bus strobes.
  always_comb begin
    state_d    = state_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    bit_cnt_d  = bit_cnt_q;
    addr_d     = addr_q;
    bus_addr_d = bus_addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    re_d       = 1'b0;
    load_d     = re_q;

    case (state_q)
      ST_WAIT_IDLE: begin
        if (cs_n_s) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (cs_fall) begin
          state_d   = ST_CMD;
          bit_cnt_d = 3'd0;
        end
      end

      ST_CMD, ST_WR, ST_RD: begin
        if (sck_rise) begin
          rx_d      = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
        end

        // The fall that closes a byte must not shift: the freshly loaded MSB is
        // what the host samples on the next rise.
        if ((state_q == ST_RD) && sck_fall && (bit_cnt_q != 3'd0)) begin
          tx_d = {tx_q[SPI_BYTE_W-2:0], 1'b0};
        end

        if (byte_done) begin
          case (state_q)
            ST_CMD: begin
              addr_d = rx_byte[ADDR_W-1:0];
              if (rx_byte[CMD_RW_BIT]) begin
                state_d = ST_WR;
              end else begin
                state_d    = ST_RD;
                re_d       = 1'b1;
                bus_addr_d = rx_byte[ADDR_W-1:0];
              end
            end
            ST_WR: begin
              we_d       = 1'b1;
              wdata_d    = rx_byte;
              bus_addr_d = addr_q;
              addr_d     = addr_q + 1'b1;
            end
            default: begin
              re_d       = 1'b1;
              bus_addr_d = addr_q + 1'b1;
              addr_d     = addr_q + 1'b1;
            end
          endcase
        end

        // A completing byte still issues its strobe before the frame closes.
        if (cs_rise) begin
          state_d   = ST_IDLE;
          bit_cnt_d = 3'd0;
        end
      end

      default: begin
        state_d = ST_WAIT_IDLE;
      end
    endcase

    // Read data arrives the cycle after reg_re; capture it into the tx shifter.
    if (load_q) begin
      tx_d = bus.reg_rdata;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_WAIT_IDLE;
      rx_q       <= '0;
      tx_q       <= '0;
      bit_cnt_q  <= 3'd0;
      addr_q     <= '0;
      bus_addr_q <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      load_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      bit_cnt_q  <= bit_cnt_d;
      addr_q     <= addr_d;
      bus_addr_q <= bus_addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      re_q       <= re_d;
      load_q     <= load_d;
    end
  end

  assign spi_miso_oe_o = (state_q == ST_RD);
  assign spi_miso_o    = spi_miso_oe_o & tx_q[SPI_BYTE_W-1];
  assign busy_o        = (state_q == ST_CMD) || (state_q == ST_WR) || (state_q == ST_RD);

  assign bus.reg_addr  = bus_addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_we    = we_q;
  assign bus.reg_re    = re_q;

endmodule
